timer_rr_sched: RTL and testbench

- Round-robin scheduler that shares one down-counting interval timer among NREQ requesters.
- Arbitrates pending requests and loads the winner's duration into the timer.
- Holds the grant while the timer runs, then pulses a per-requester done.
- Sits between client blocks that need timed exclusive slots and the single shared counter datapath.

---
 rtl/timer_sched_pkg.sv | 21 ++
 rtl/tmr_down_cnt.sv | 29 ++
 rtl/timer_rr_sched.sv | 139 +++++++++++++
 tb/tb_timer_rr_sched.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_sched_pkg.sv
// Shared definitions for the round-robin interval-timer scheduler:
// FSM state encodings and a constant-width helper.
package timer_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tmr_down_cnt.sv
// Loadable down counter that saturates at zero; asynchronous clear.
module tmr_down_cnt #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          zero
);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - CW'(1);
    end
  end

  assign count = count_reg;
  assign zero  = (count_reg == '0);

endmodule

// File: rtl/timer_rr_sched.sv
// Round-robin arbiter handing one shared down-counting timer to NREQ requesters,
// one timed exclusive slot at a time, with done/aborted completion reporting.
module timer_rr_sched
  import timer_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int CW   = 4,
  parameter int IW   = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*CW-1:0] dur,
  output logic [NREQ-1:0]    gnt,
  output logic [IW-1:0]      gnt_id,
  output logic               busy,
  output logic [CW-1:0]      count,
  output logic [NREQ-1:0]    done,
  output logic               aborted
);

  // One extra bit so ptr+offset cannot overflow before the modulo fold.
  localparam int SW = clog2(NREQ) + 1;

  state_t        state_reg, state_next;
  logic [IW-1:0] ptr_reg, ptr_next;
  logic [IW-1:0] gnt_id_reg, gnt_id_next;
  logic          aborted_reg, aborted_next;

  logic [IW-1:0] cand_idx [NREQ];
  logic [NREQ-1:0] cand_hit;
  logic [CW-1:0] dur_arr [NREQ];
  logic [IW-1:0] win_idx;
  logic          req_held;
  logic          tmr_load, tmr_en, tmr_zero;
  logic          slot_active, slot_done;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : gen_rr
      logic [SW-1:0] sum;
      assign sum          = SW'(ptr_reg) + SW'(gi);
      assign cand_idx[gi] = (sum >= SW'(NREQ)) ? IW'(sum - SW'(NREQ)) : IW'(sum);
      assign cand_hit[gi] = req[cand_idx[gi]];
      assign dur_arr[gi]  = dur[gi*CW +: CW];
    end
  endgenerate

  // Lowest search offset wins, so the pointer position has top priority.
  always_comb begin
    win_idx = cand_idx[0];
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (cand_hit[i]) win_idx = cand_idx[i];
    end
  end

  assign req_held = req[gnt_id_reg];

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_id_next  = gnt_id_reg;
    aborted_next = aborted_reg;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          gnt_id_next = win_idx;
          state_next  = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (!req_held) begin
          aborted_next = 1'b1;
          state_next   = ST_DONE;
        end else begin
          tmr_load   = 1'b1;
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        // Withdrawal wins over expiry so the flag reflects the abort.
        if (!req_held) begin
          aborted_next = 1'b1;
          state_next   = ST_DONE;
        end else if (tmr_zero) begin
          state_next = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        ptr_next     = (gnt_id_reg == IW'(NREQ - 1)) ? '0 : gnt_id_reg + IW'(1);
        aborted_next = 1'b0;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      gnt_id_reg  <= '0;
      aborted_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_id_reg  <= gnt_id_next;
      aborted_reg <= aborted_next;
    end
  end

  tmr_down_cnt #(.CW(CW)) u_tmr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (dur_arr[gnt_id_reg]),
    .en       (tmr_en),
    .count    (count),
    .zero     (tmr_zero)
  );

  assign slot_active = (state_reg == ST_LOAD) || (state_reg == ST_RUN);
  assign slot_done   = (state_reg == ST_DONE);

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : gen_dec
      assign gnt[gi]  = slot_active && (gnt_id_reg == IW'(gi));
      assign done[gi] = slot_done && (gnt_id_reg == IW'(gi));
    end
  endgenerate

  assign busy    = slot_active;
  assign gnt_id  = gnt_id_reg;
  assign aborted = aborted_reg;

endmodule

// File: tb/tb_timer_rr_sched.sv
// Self-checking bench for timer_rr_sched: vector table, directed corner
// sequences, and randomized traffic against a slot-level reference model.
module tb_timer_rr_sched;

  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int IW   = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [3:0]  req = '0;
  logic [15:0] dur = '0;
  logic [3:0]  gnt, done, count;
  logic [1:0]  gnt_id;
  logic        busy, aborted;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  timer_rr_sched #(.NREQ(NREQ), .CW(CW), .IW(IW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .dur     (dur),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .count   (count),
    .done    (done),
    .aborted (aborted)
  );

  typedef struct {
    bit          rst;
    logic [3:0]  req;
    logic [15:0] dur;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [15:0] pk(input logic [3:0] g, input logic [1:0] id, input logic b,
                                     input logic [3:0] c, input logic [3:0] d, input logic a);
    return {g, id, b, c, d, a};
  endfunction

  function automatic logic [15:0] obs();
    return pk(gnt, gnt_id, busy, count, done, aborted);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end else begin
      $display("ok   %s: %0h", nm, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic wait_busy_count(input logic [3:0] v, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      tick();
      if (busy && count == v) hit = 1'b1;
    end
    chk(nm, 32'(hit), 32'd1);
  endtask

  // Reference model: tracks whose slot it is and how much time is left.
  int m_ptr, m_owner, m_cnt;
  bit m_active, m_fresh, m_fin, m_ab;

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0;
    m_active = 0; m_fresh = 0; m_fin = 0; m_ab = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [15:0] d);
    bit found;
    if (m_fin) begin
      m_ptr = (m_owner + 1) % NREQ;
      m_fin = 0;
      m_ab  = 0;
    end else if (!m_active) begin
      found = 0;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!found && r[c]) begin
          found = 1; m_owner = c; m_active = 1; m_fresh = 1;
        end
      end
    end else if (!r[m_owner]) begin
      m_active = 0; m_fin = 1; m_ab = 1;
    end else if (m_fresh) begin
      m_fresh = 0;
      m_cnt   = int'((d >> (4 * m_owner)) & 16'hF);
    end else if (m_cnt == 0) begin
      m_active = 0; m_fin = 1;
    end else begin
      m_cnt = m_cnt - 1;
    end
  endtask

  function automatic logic [15:0] model_out();
    logic [3:0] oh;
    oh = 4'(1 << m_owner);
    return pk(m_active ? oh : 4'b0, 2'(m_owner), m_active, 4'(m_cnt), m_fin ? oh : 4'b0, m_ab);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single slot, dur[2]=3; then a stream of zero-length slots.
    vecs.push_back('{1, 4'b0100, 16'h0300, pk(4'b0100, 2'd2, 1, 4'd0, 4'b0000, 0)});
    vecs.push_back('{0, 4'b0100, 16'h0300, pk(4'b0100, 2'd2, 1, 4'd3, 4'b0000, 0)});
    vecs.push_back('{0, 4'b0100, 16'h0300, pk(4'b0100, 2'd2, 1, 4'd2, 4'b0000, 0)});
    vecs.push_back('{0, 4'b0100, 16'h0300, pk(4'b0100, 2'd2, 1, 4'd1, 4'b0000, 0)});
    vecs.push_back('{0, 4'b0100, 16'h0300, pk(4'b0100, 2'd2, 1, 4'd0, 4'b0000, 0)});
    vecs.push_back('{0, 4'b0100, 16'h0300, pk(4'b0000, 2'd2, 0, 4'd0, 4'b0100, 0)});
    vecs.push_back('{0, 4'b0000, 16'h0300, pk(4'b0000, 2'd2, 0, 4'd0, 4'b0000, 0)});
    for (int k = 0; k < 6; k++) begin
      logic [3:0] oh;
      logic [1:0] id;
      id = 2'(k % 4);
      oh = 4'(1 << id);
      vecs.push_back('{k == 0, 4'b1111, 16'h0000, pk(oh, id, 1, 4'd0, 4'b0000, 0)});
      vecs.push_back('{0, 4'b1111, 16'h0000, pk(oh, id, 1, 4'd0, 4'b0000, 0)});
      vecs.push_back('{0, 4'b1111, 16'h0000, pk(4'b0000, id, 0, 4'd0, oh, 0)});
      vecs.push_back('{0, 4'b1111, 16'h0000, pk(4'b0000, id, 0, 4'd0, 4'b0000, 0)});
    end

    #1 reset_n = 1'b0;
    #2 chk("reset_state", 32'(obs()), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      req = vecs[i].req;
      dur = vecs[i].dur;
      tick();
      chk($sformatf("row%0d", i), 32'(obs()), 32'(vecs[i].exp));
    end

    // Asynchronous reset mid-RUN; pointer (currently 2) must return to 0.
    req = 4'b0001;
    dur = 16'h0009;
    wait_busy_count(4'd5, "t1_reach5");
    reset_n = 1'b0;
    #1 chk("t1_async_clear", 32'(obs()), 32'd0);
    #1 req = 4'b1111;
    reset_n = 1'b1;
    tick();
    chk("t1_first_grant", 32'({gnt, gnt_id}), 32'({4'b0001, 2'd0}));

    // Maximum and minimum durations.
    do_reset();
    req = 4'b1000;
    dur = 16'hF000;
    begin
      int gcnt, seq_err;
      logic [3:0] dcnt, dmask;
      gcnt = 0; seq_err = 0; dcnt = 4'hX; dmask = 4'h0;
      for (int i = 0; i < 40; i++) begin
        tick();
        if (gnt != 0) begin
          gcnt++;
          if (gcnt >= 2 && count != 4'(17 - gcnt)) seq_err++;
        end
        if (done != 0) begin
          dcnt = count; dmask = done;
          break;
        end
      end
      chk("t4_gnt_cycles_15", 32'(gcnt), 32'd17);
      chk("t4_count_seq_15", 32'(seq_err), 32'd0);
      chk("t4_no_wrap", 32'(dcnt), 32'd0);
      chk("t4_done_mask", 32'(dmask), 32'b1000);
      dur = 16'h0000;
      gcnt = 0;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (gnt != 0) gcnt++;
        if (done != 0) break;
      end
      chk("t4_gnt_cycles_0", 32'(gcnt), 32'd2);
    end

    // Abort by withdrawal, then pointer-ordered fairness.
    do_reset();
    req = 4'b0010;
    dur = 16'h2292;
    wait_busy_count(4'd5, "t5_reach5");
    req = 4'b0101;
    tick();
    chk("t5_abort_done", 32'({done, aborted, busy, count}), 32'({4'b0010, 1'b1, 1'b0, 4'd5}));
    tick();
    chk("t5_idle_clear", 32'({done, aborted}), 32'd0);
    tick();
    chk("t5_next_grant", 32'({gnt, gnt_id}), 32'({4'b0100, 2'd2}));
    req = 4'b1001;
    tick();
    chk("t6_abort2", 32'({done, aborted}), 32'({4'b0100, 1'b1}));
    tick();
    begin
      logic [5:0] order;
      int n;
      logic [3:0] prev;
      order = '0; n = 0; prev = '0;
      for (int i = 0; i < 80 && n < 3; i++) begin
        tick();
        if (gnt != 0 && prev == 0) begin
          order = {order[3:0], gnt_id};
          n++;
          if (gnt_id == 2'd3) req = req | 4'b0100;
        end
        if (done != 0) req = req & ~done;
        prev = gnt;
      end
      chk("t6_grant_count", 32'(n), 32'd3);
      chk("t6_order_3_0_2", 32'(order), 32'({2'd3, 2'd0, 2'd2}));
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 300; cyc++) begin
      logic [3:0] r;
      r = req;
      for (int b = 0; b < 4; b++) begin
        if (!r[b]) r[b] = ($urandom_range(0, 9) < 3);
        else if ($urandom_range(0, 19) == 0) r[b] = 1'b0;
      end
      req = r;
      dur = 16'($urandom);
      tick();
      model_step(r, dur);
      chk($sformatf("rand%0d", cyc), 32'(obs()), 32'(model_out()));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
